// File: rtl/vga_window_cmp.sv
// rtl/vga_window_cmp.sv - pipelined multi-channel coordinate window comparator
// Optional VGA_CMP_STICKY_EN adds out_sticky, a per-segment union of inside hits.
module vga_window_cmp #(
   parameter int WIDTH    = 10,
   parameter int CHANNELS = 4,
   localparam int IW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [IW-1:0]       cfg_sel,
   input  logic [WIDTH-1:0]    cfg_lo,
   input  logic [WIDTH-1:0]    cfg_hi,
   input  logic                in_valid,
   input  logic [WIDTH-1:0]    in_value,
   input  logic                in_last,
   output logic                out_valid,
   output logic [CHANNELS-1:0] out_lower,
   output logic [CHANNELS-1:0] out_greater,
   output logic [CHANNELS-1:0] out_inside,
   output logic [CHANNELS-1:0] out_enter,
   output logic [CHANNELS-1:0] out_exit,
   output logic                out_hit_any,
   output logic [IW-1:0]       out_hit_idx,
   output logic                out_last
`ifdef VGA_CMP_STICKY_EN
   ,
   output logic [CHANNELS-1:0] out_sticky
`endif
);

   logic [WIDTH-1:0]    lo_q [CHANNELS];
   logic [WIDTH-1:0]    hi_q [CHANNELS];
   logic [CHANNELS-1:0] lower_c, greater_c;
   logic                s1_valid, s1_last;
   logic [CHANNELS-1:0] s1_lower, s1_greater, s1_inside;
   logic [CHANNELS-1:0] prev_inside;
   logic [IW-1:0]       hit_idx_c;

   // A select matching no channel writes nothing, so out-of-range cfg_sel is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            lo_q[i] <= '0;
            hi_q[i] <= '1;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_we && cfg_sel == IW'(i)) begin
               lo_q[i] <= cfg_lo;
               hi_q[i] <= cfg_hi;
            end
         end
      end
   end

   always_comb begin
      lower_c   = '0;
      greater_c = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         lower_c[i]   = in_value < lo_q[i];
         greater_c[i] = in_value > hi_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s1_lower   <= '0;
         s1_greater <= '0;
         s1_inside  <= '0;
      end else begin
         s1_valid   <= in_valid;
         s1_last    <= in_valid & in_last;
         s1_lower   <= lower_c;
         s1_greater <= greater_c;
         s1_inside  <= ~lower_c & ~greater_c;
      end
   end

   // Lowest index wins, so scan from the top down.
   always_comb begin
      hit_idx_c = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (s1_inside[i]) hit_idx_c = IW'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_lower   <= '0;
         out_greater <= '0;
         out_inside  <= '0;
         out_enter   <= '0;
         out_exit    <= '0;
         out_hit_any <= 1'b0;
         out_hit_idx <= '0;
         prev_inside <= '0;
      end else begin
         out_valid <= s1_valid;
         out_last  <= s1_valid & s1_last;
         if (s1_valid) begin
            out_lower   <= s1_lower;
            out_greater <= s1_greater;
            out_inside  <= s1_inside;
            out_enter   <= s1_inside & ~prev_inside;
            out_exit    <= ~s1_inside & prev_inside;
            out_hit_any <= |s1_inside;
            out_hit_idx <= hit_idx_c;
            prev_inside <= s1_last ? '0 : s1_inside;
         end else begin
            out_lower   <= '0;
            out_greater <= '0;
            out_inside  <= '0;
            out_enter   <= '0;
            out_exit    <= '0;
            out_hit_any <= 1'b0;
            out_hit_idx <= '0;
         end
      end
   end

`ifdef VGA_CMP_STICKY_EN
   logic sticky_clr;

   // Clear lands one edge after the last result; a same-edge inside sample re-sets it.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_sticky <= '0;
         sticky_clr <= 1'b0;
      end else begin
         sticky_clr <= s1_valid & s1_last;
         out_sticky <= (sticky_clr ? '0 : out_sticky) | (s1_valid ? s1_inside : '0);
      end
   end
`endif

endmodule
